otp_session_arbiter: RTL
========================

// Module: otp_session_arbiter
// PURPOSE
//  Shares one OTP authenticator (LFSR + OTP fsm) between N_REQ keypad terminals. Grants one terminal
//  at a time in round-robin order and forwards its digit/latch stream. Holds the authenticator in reset
//  between sessions. Ends each session on unlock, lockout, expiry, abort or inactivity, and reports a result code.
// PARAMETERS
//  N_REQ        4            number of requesting terminals (2..8)
//  IDLE_TMO     1_000_000    clk cycles without a granted-lane latch before session is killed (>=2)
// PORTS
//  clk              in   1        system clock; all logic rising-edge
//  reset            in   1        synchronous, active-high reset
//  req              in   N_REQ    per-terminal session request level (held for whole session)
//  req_digit        in   4*N_REQ  lane i digit at [4i+3:4i]
//  req_latch        in   N_REQ    lane i one-cycle digit strobe
//  grant            out  N_REQ    one-hot, registered; lane currently owning authenticator
//  grant_id         out  clog2(N) index of granted lane (valid when busy)
//  busy             out  1        high in GRANT/SESSION/RELEASE
//  auth_rst_n       out  1        active-low reset to authenticator; high only in SESSION
//  auth_digit       out  4        registered copy of granted lane digit
//  auth_latch       out  1        registered copy of granted lane latch (SESSION only)
//  auth_unlock      in   1        authenticator unlock
//  auth_reset_sys   in   1        authenticator lockout (3 wrong attempts)
//  auth_expired     in   1        authenticator OTP expiry
//  result_valid     out  1        one-cycle pulse in RELEASE
//  result_code      out  3        1 UNLOCK, 2 LOCKOUT, 3 EXPIRED, 4 ABORT, 5 TIMEOUT; 0 otherwise
//  result_id        out  clog2(N) lane the result belongs to
// BEHAVIOUR
//  Reset: state IDLE; grant=0, grant_id=0, busy=0, auth_rst_n=0, auth_digit=0, auth_latch=0,
//   result_valid=0, result_code=0, result_id=0, rr pointer=N_REQ-1, must_drop=0, idle counter=0.
//   Reset mid-session drops the grant immediately and emits no result.
//  Eligible lanes: elig = req & ~must_drop. must_drop[i] is set when lane i's session ends.
//   It clears on the first cycle req[i]==0, so a lane must drop req before it can be re-granted.
//  IDLE: auth_rst_n=0. If elig!=0, pick the first set bit searching ptr+1, ptr+2, ... (mod N_REQ).
//   Register grant/grant_id and go to GRANT.
//  GRANT (1 cycle): auth_rst_n=0; clear idle counter; go to SESSION. req->auth_rst_n high latency = 2 clk.
//  SESSION: auth_rst_n=1. Each cycle: auth_digit<=req_digit[grant_id], auth_latch<=req_latch[grant_id].
//   Forwarding latency is 1 clk. Latches on non-granted lanes are ignored (dropped, not queued).
//   The idle counter increments each cycle and clears on a granted-lane latch.
//   The end condition is evaluated each cycle. Priority when several hold in the same cycle:
//   auth_unlock > auth_reset_sys > auth_expired > !req[grant_id] (ABORT) > counter==IDLE_TMO-1 (TIMEOUT).
//   On end: capture code, go to RELEASE, auth_latch forced 0 that cycle.
//  RELEASE (1 cycle): auth_rst_n=0; result_valid=1 with code and result_id=grant_id.
//   ptr<=grant_id; must_drop[grant_id]<=1; grant<=0; then IDLE.
//   A new grant is issued no earlier than 2 clk after RELEASE, i.e. at least 2 auth_rst_n-low cycles between sessions.
//  Widths: idle counter = clog2(IDLE_TMO+1) bits, saturates, never wraps.
//   ptr wraps N_REQ-1 -> 0. auth_* inputs are ignored outside SESSION.
//  Only one lane is ever granted; grant is zero outside GRANT/SESSION/RELEASE.
// STRUCTURE
//  otp_arb_pkg: state enum {IDLE,GRANT,SESSION,RELEASE}; RES_* result-code localparams.
//  Sub-module rr_arbiter: combinational round-robin picker (inputs elig, ptr; outputs onehot, idx, any).
//   The pointer register stays in otp_session_arbiter.
// TESTING
//  1 Single lane: req[1]=1, four latches digits 1,2,3,4, auth_unlock pulse
//    -> grant=4'b0010 after 1 clk, auth_rst_n high at +2, digits appear on auth_digit 1 clk later,
//       result_code=1, result_id=1.
//  2 Round-robin: req=4'b1111 from reset, each session ends by ABORT after lane drops req
//    -> grant order 0,1,2,3,0, each re-grant only after that lane drops and reasserts req.
//  3 Non-granted latch: lane 0 granted, lane 2 pulses req_latch with digit 9
//    -> auth_latch stays 0, lane 2 not granted until lane 0 session ends.
//  4 Simultaneous end: auth_unlock and auth_reset_sys high same cycle -> result_code=1 (UNLOCK).
//    Then auth_expired with req drop -> result_code=3.
//  5 Inactivity: IDLE_TMO=16, grant then no latches -> result_code=5 exactly 16 SESSION cycles after entry.
//    One latch at cycle 10 restarts the count.
//  6 Reset mid-session: reset in SESSION -> next clk grant=0, auth_rst_n=0, result_valid never pulses.
//    Arbitration restarts from lane 0.

Source files
------------

// File: rtl/otp_session_arbiter_pkg.sv
// Shared types for the OTP session arbiter: controller states and session result codes.
package otp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SESSION = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [2:0] RES_NONE    = 3'd0;
    localparam logic [2:0] RES_UNLOCK  = 3'd1;
    localparam logic [2:0] RES_LOCKOUT = 3'd2;
    localparam logic [2:0] RES_EXPIRED = 3'd3;
    localparam logic [2:0] RES_ABORT   = 3'd4;
    localparam logic [2:0] RES_TIMEOUT = 3'd5;

endpackage

// File: rtl/otp_session_arbiter_if.sv
// Terminal-side and authenticator-side signals of the OTP session arbiter.
interface otp_session_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IW = $clog2(N_REQ);

    // req is a level held for the whole session; req_latch and auth_* are one-cycle strobes;
    // grant/auth_* outputs are registered and change only on the rising clock edge.
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] req_digit;
    logic [N_REQ-1:0]   req_latch;
    logic [N_REQ-1:0]   grant;
    logic [IW-1:0]      grant_id;
    logic               busy;
    logic               auth_rst_n;
    logic [3:0]         auth_digit;
    logic               auth_latch;
    logic               auth_unlock;
    logic               auth_reset_sys;
    logic               auth_expired;
    logic               result_valid;
    logic [2:0]         result_code;
    logic [IW-1:0]      result_id;

    modport master (
        output req, req_digit, req_latch, auth_unlock, auth_reset_sys, auth_expired,
        input  grant, grant_id, busy, auth_rst_n, auth_digit, auth_latch,
               result_valid, result_code, result_id
    );

    modport slave (
        input  req, req_digit, req_latch, auth_unlock, auth_reset_sys, auth_expired,
        output grant, grant_id, busy, auth_rst_n, auth_digit, auth_latch,
               result_valid, result_code, result_id
    );

endinterface

// File: rtl/otp_session_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible lane after ptr_i, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr_i) + k) % N_REQ);
            if (!any_o && elig_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/otp_session_arbiter.sv
// Shares one OTP authenticator between N_REQ keypad terminals, one round-robin session at a time.
module otp_session_arbiter
    import otp_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int IDLE_TMO = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    otp_session_arbiter_if.slave  bus,
    output state_t                state_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(IDLE_TMO + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(IDLE_TMO - 1);

    state_t           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [IW-1:0]    grant_id_q;
    logic [IW-1:0]    ptr_q;
    logic [N_REQ-1:0] must_drop_q, must_drop_d;
    logic [CW-1:0]    idle_cnt_q;
    logic             busy_q;
    logic             auth_rst_n_q;
    logic [3:0]       auth_digit_q;
    logic             auth_latch_q;
    logic             result_valid_q;
    logic [2:0]       result_code_q;
    logic [IW-1:0]    result_id_q;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [3:0]       lane_digit;
    logic             lane_latch;
    logic             lane_req;
    logic [2:0]       end_code;

    assign elig = bus.req & ~must_drop_q;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .elig_i   (elig),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        lane_digit = bus.req_digit[{grant_id_q, 2'b00} +: 4];
        lane_latch = bus.req_latch[grant_id_q];
        lane_req   = bus.req[grant_id_q];

        // Highest-priority end reason wins when several coincide.
        end_code = RES_NONE;
        if (bus.auth_unlock)              end_code = RES_UNLOCK;
        else if (bus.auth_reset_sys)      end_code = RES_LOCKOUT;
        else if (bus.auth_expired)        end_code = RES_EXPIRED;
        else if (!lane_req)               end_code = RES_ABORT;
        else if (idle_cnt_q == TMO_LAST)  end_code = RES_TIMEOUT;

        // A served lane stays ineligible until it has been seen with req low.
        must_drop_d = must_drop_q & bus.req;
        if (state_q == RELEASE) must_drop_d[grant_id_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            grant_id_q     <= '0;
            ptr_q          <= IW'(N_REQ - 1);
            must_drop_q    <= '0;
            idle_cnt_q     <= '0;
            busy_q         <= 1'b0;
            auth_rst_n_q   <= 1'b0;
            auth_digit_q   <= 4'd0;
            auth_latch_q   <= 1'b0;
            result_valid_q <= 1'b0;
            result_code_q  <= RES_NONE;
            result_id_q    <= '0;
        end else begin
            must_drop_q <= must_drop_d;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q    <= pick_onehot;
                        grant_id_q <= pick_idx;
                        busy_q     <= 1'b1;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    idle_cnt_q   <= '0;
                    auth_rst_n_q <= 1'b1;
                    state_q      <= SESSION;
                end
                SESSION: begin
                    auth_digit_q <= lane_digit;
                    if (end_code != RES_NONE) begin
                        auth_latch_q   <= 1'b0;
                        auth_rst_n_q   <= 1'b0;
                        result_valid_q <= 1'b1;
                        result_code_q  <= end_code;
                        result_id_q    <= grant_id_q;
                        state_q        <= RELEASE;
                    end else begin
                        auth_latch_q <= lane_latch;
                        if (lane_latch)              idle_cnt_q <= '0;
                        else if (idle_cnt_q != '1)   idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    result_valid_q <= 1'b0;
                    result_code_q  <= RES_NONE;
                    result_id_q    <= '0;
                    ptr_q          <= grant_id_q;
                    grant_q        <= '0;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant        = grant_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.busy         = busy_q;
    assign bus.auth_rst_n   = auth_rst_n_q;
    assign bus.auth_digit   = auth_digit_q;
    assign bus.auth_latch   = auth_latch_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_code  = result_code_q;
    assign bus.result_id    = result_id_q;
    assign state_o          = state_q;

endmodule
